// File: rtl/gray_pkg.sv
// Shared Gray-code constants and width-generic conversion helpers.
package gray_pkg;

    localparam logic MODE_B2G = 1'b0;
    localparam logic MODE_G2B = 1'b1;

    localparam int unsigned MAX_WIDTH = 32;

    // Binary to Gray over the low w bits; bits at and above w must be zero.
    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b,
                                                      input int                   w);
        logic [MAX_WIDTH-1:0] g;
        logic [MAX_WIDTH-1:0] bs;
        g  = '0;
        bs = b >> 1;
        for (int i = 0; i < int'(MAX_WIDTH); i++) begin
            if (i < w) begin
                g[i] = b[i] ^ bs[i];
            end
        end
        return g;
    endfunction

    // Gray to binary as a prefix XOR running down from bit w-1.
    function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g,
                                                      input int                   w);
        logic [MAX_WIDTH-1:0] bin;
        logic                 acc;
        bin = '0;
        acc = 1'b0;
        for (int i = int'(MAX_WIDTH) - 1; i >= 0; i--) begin
            if (i < w) begin
                acc    = acc ^ g[i];
                bin[i] = acc;
            end
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_step_check.sv
// Flags any Gray input that moves more than one bit from the previous Gray input.
module gray_step_check #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_xfer,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_step_err
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_prev;
    logic             r_hist_valid;
    logic             r_step_err;
    logic [WIDTH-1:0] w_diff;
    logic [CNT_W-1:0] w_diff_cnt;

    assign w_diff     = i_data ^ r_prev;
    assign w_diff_cnt = CNT_W'($countones(w_diff));
    assign o_step_err = r_step_err;

    // First word after reset only seeds the history; the flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev       <= '0;
            r_hist_valid <= 1'b0;
            r_step_err   <= 1'b0;
        end else if (i_xfer) begin
            r_prev       <= i_data;
            r_hist_valid <= 1'b1;
            if (r_hist_valid && (w_diff_cnt > CNT_W'(1))) begin
                r_step_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/gray_conv_pipe.sv
// Registered binary<->Gray converter with valid/ready handshake.
// Optional Gray step checker enabled by defining GRAY_STEP_CHECK_EN.
module gray_conv_pipe
    import gray_pkg::*;
#(
    parameter int unsigned      WIDTH    = 4,
    parameter logic [WIDTH-1:0] RST_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode,
    output logic             step_err
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_mode;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [WIDTH-1:0] w_conv;

    assign in_ready   = !r_out_valid || out_ready;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = r_out_valid && out_ready;

    assign w_conv = (in_mode == MODE_G2B)
                  ? WIDTH'(gray2bin(MAX_WIDTH'(in_data), int'(WIDTH)))
                  : WIDTH'(bin2gray(MAX_WIDTH'(in_data), int'(WIDTH)));

    // A new word always wins over draining the held one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= RST_DATA;
            r_out_mode  <= 1'b0;
        end else if (w_in_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_conv;
            r_out_mode  <= in_mode;
        end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_mode  = r_out_mode;

`ifdef GRAY_STEP_CHECK_EN
    gray_step_check #(
        .WIDTH (WIDTH)
    ) u_step_check (
        .clk        (clk),
        .rst        (rst),
        .i_xfer     (w_in_xfer && (in_mode == MODE_G2B)),
        .i_data     (in_data),
        .o_step_err (step_err)
    );
`else
    assign step_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_conv_pipe.sv
// Directed self-checking bench for gray_conv_pipe (WIDTH=4 and WIDTH=8 instances).
module tb_gray_conv_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_mode;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       out_mode;
    logic       step_err;

    logic       v8_in_valid;
    logic       v8_in_ready;
    logic       v8_in_mode;
    logic [7:0] v8_in_data;
    logic       v8_out_valid;
    logic       v8_out_ready;
    logic [7:0] v8_out_data;
    logic       v8_out_mode;
    logic       v8_step_err;

    int n_cmp;
    int n_fail;

`ifdef GRAY_STEP_CHECK_EN
    localparam logic STEP_EXP = 1'b1;
`else
    localparam logic STEP_EXP = 1'b0;
`endif

    gray_conv_pipe #(.WIDTH(4), .RST_DATA(4'h5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_mode(out_mode), .step_err(step_err)
    );

    gray_conv_pipe #(.WIDTH(8), .RST_DATA(8'h00)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(v8_in_valid), .in_ready(v8_in_ready), .in_mode(v8_in_mode), .in_data(v8_in_data),
        .out_valid(v8_out_valid), .out_ready(v8_out_ready), .out_data(v8_out_data),
        .out_mode(v8_out_mode), .step_err(v8_step_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_cmp++;
        if (out_data !== 4'h5) begin n_fail++; $display("FAIL reset_data: got %h expected 5", out_data); end
        n_cmp++;
        if (out_mode !== 1'b0) begin n_fail++; $display("FAIL reset_mode: got %b expected 0", out_mode); end
        n_cmp++;
        if (step_err !== 1'b0) begin n_fail++; $display("FAIL reset_step_err: got %b expected 0", step_err); end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        out_ready = 1'b1;
        in_valid  = 1'b1; in_mode = 1'b0; in_data = 4'b1011;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 4'b1110 || out_mode !== 1'b0) begin
            n_fail++; $display("FAIL b2g_1011: got v=%b d=%b m=%b expected v=1 d=1110 m=0", out_valid, out_data, out_mode);
        end
        in_valid = 1'b1; in_mode = 1'b1; in_data = 4'b1110;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 4'b1011 || out_mode !== 1'b1) begin
            n_fail++; $display("FAIL g2b_1110: got v=%b d=%b m=%b expected v=1 d=1011 m=1", out_valid, out_data, out_mode);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 4'b1011) begin
            n_fail++; $display("FAIL drain: got v=%b d=%b expected v=0 d=1011", out_valid, out_data);
        end
    endtask

    task automatic test_roundtrip();
        logic [3:0] g;
        out_ready = 1'b1;
        for (int v = 0; v < 16; v++) begin
            in_valid = 1'b1; in_mode = 1'b0; in_data = 4'(v);
            tick();
            g = out_data;
            n_cmp++;
            if (g !== (4'(v) ^ (4'(v) >> 1))) begin
                n_fail++; $display("FAIL rt_b2g[%0d]: got %b expected %b", v, g, 4'(v) ^ (4'(v) >> 1));
            end
            in_mode = 1'b1; in_data = g;
            tick();
            n_cmp++;
            if (out_data !== 4'(v)) begin
                n_fail++; $display("FAIL rt_g2b[%0d]: got %b expected %b", v, out_data, 4'(v));
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 1'b0; in_data = 4'b0011;
        tick();
        in_data = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 4'b0010 || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got v=%b d=%b rdy=%b expected v=1 d=0010 rdy=0", c, out_valid, out_data, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_comb: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 4'b0110) begin
            n_fail++; $display("FAIL bp_replace: got v=%b d=%b expected v=1 d=0110", out_valid, out_data);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 4'b0110) begin
            n_fail++; $display("FAIL bp_drain: got v=%b d=%b expected v=0 d=0110", out_valid, out_data);
        end
    endtask

    task automatic test_streaming();
        logic [3:0] gtab [16];
        logic [3:0] prev;
        gtab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
        prev = 4'h0;
        out_ready = 1'b1;
        in_mode   = 1'b0;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1; in_data = 4'(i % 16);
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== gtab[i % 16]) begin
                n_fail++; $display("FAIL stream[%0d]: got v=%b d=%b expected v=1 d=%b", i, out_valid, out_data, gtab[i % 16]);
            end
            if (i > 0) begin
                n_cmp++;
                if ($countones(out_data ^ prev) != 1) begin
                    n_fail++; $display("FAIL stream_step[%0d]: got %b after %b expected one-bit change", i, out_data, prev);
                end
            end
            prev = out_data;
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 1'b1; in_data = 4'b1111;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 4'b1010) begin
            n_fail++; $display("FAIL mid_load: got v=%b d=%b expected v=1 d=1010", out_valid, out_data);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 4'h5 || out_mode !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: got v=%b d=%h m=%b expected v=0 d=5 m=0", out_valid, out_data, out_mode);
        end
        out_ready = 1'b1;
        in_valid = 1'b1; in_mode = 1'b0; in_data = 4'b0110;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 4'b0101) begin
            n_fail++; $display("FAIL post_reset: got v=%b d=%b expected v=1 d=0101", out_valid, out_data);
        end
        tick();
    endtask

    task automatic test_width8();
        v8_out_ready = 1'b1;
        v8_in_valid = 1'b1; v8_in_mode = 1'b0; v8_in_data = 8'hFF;
        tick();
        n_cmp++;
        if (v8_out_valid !== 1'b1 || v8_out_data !== 8'h80) begin
            n_fail++; $display("FAIL w8_b2g: got v=%b d=%h expected v=1 d=80", v8_out_valid, v8_out_data);
        end
        v8_in_mode = 1'b1; v8_in_data = 8'h80;
        tick();
        v8_in_valid = 1'b0;
        n_cmp++;
        if (v8_out_valid !== 1'b1 || v8_out_data !== 8'hFF || v8_out_mode !== 1'b1) begin
            n_fail++; $display("FAIL w8_g2b: got v=%b d=%h m=%b expected v=1 d=FF m=1", v8_out_valid, v8_out_data, v8_out_mode);
        end
        v8_in_valid = 1'b1; v8_in_mode = 1'b0; v8_in_data = 8'h00;
        tick();
        v8_in_valid = 1'b0;
        n_cmp++;
        if (v8_out_data !== 8'h00) begin
            n_fail++; $display("FAIL w8_zero: got %h expected 00", v8_out_data);
        end
        tick();
    endtask

    task automatic test_step_check();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_mode = 1'b1; in_data = 4'b0000;
        tick();
        n_cmp++;
        if (step_err !== 1'b0) begin n_fail++; $display("FAIL step_first: got %b expected 0", step_err); end
        in_data = 4'b0001;
        tick();
        n_cmp++;
        if (step_err !== 1'b0) begin n_fail++; $display("FAIL step_one_bit: got %b expected 0", step_err); end
        in_data = 4'b0111;
        tick();
        n_cmp++;
        if (step_err !== STEP_EXP || out_data !== 4'b0101) begin
            n_fail++; $display("FAIL step_two_bit: got err=%b d=%b expected err=%b d=0101", step_err, out_data, STEP_EXP);
        end
        in_mode = 1'b0; in_data = 4'b1111;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (step_err !== STEP_EXP) begin n_fail++; $display("FAIL step_sticky: got %b expected %b", step_err, STEP_EXP); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (step_err !== 1'b0) begin n_fail++; $display("FAIL step_clear: got %b expected 0", step_err); end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst = 1'b1;
        in_valid = 1'b0; in_mode = 1'b0; in_data = 4'h0; out_ready = 1'b0;
        v8_in_valid = 1'b0; v8_in_mode = 1'b0; v8_in_data = 8'h00; v8_out_ready = 1'b0;
        test_reset();
        test_directed();
        test_roundtrip();
        test_backpressure();
        test_streaming();
        test_reset_mid();
        test_width8();
        test_step_check();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
